// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths and the queued MDU result record
package wb_port_arbiter_pkg;
   localparam int XLEN = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NREGS = 1 << REG_ADDR_W;
   localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;
endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: synchronous FIFO of pending MDU writeback results
module wb_result_fifo
   import wb_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  wb_entry_t              din,
   output wb_entry_t              head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   wb_entry_t mem [DEPTH];
   logic [AW-1:0] wp, rp;
   assign head  = mem[rp];
   assign full  = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   always_ff @(posedge clk)
      if (push) mem[wp] <= din;
   // Power-of-two depth lets the pointers wrap by plain overflow
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         wp    <= wp + AW'(push);
         rp    <= rp + AW'(pop);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between writeback and queued MDU results,
// with a starvation-forced drain and a busy scoreboard for decode hazards.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        pipe_we,
   input  logic [REG_ADDR_W-1:0]       pipe_rd,
   input  logic [XLEN-1:0]             pipe_data,
   output logic                        pipe_stall,
   input  logic                        mdu_valid,
   output logic                        mdu_ready,
   input  logic [REG_ADDR_W-1:0]       mdu_rd,
   input  logic [XLEN-1:0]             mdu_data,
   input  logic                        issue_valid,
   input  logic [REG_ADDR_W-1:0]       issue_rd,
   input  logic [REG_ADDR_W-1:0]       rs1,
   input  logic [REG_ADDR_W-1:0]       rs2,
   input  logic [REG_ADDR_W-1:0]       dec_rd,
   output logic                        hazard_rs1,
   output logic                        hazard_rs2,
   output logic                        hazard_rd,
   output logic                        rf_we,
   output logic [REG_ADDR_W-1:0]       rf_rd,
   output logic [XLEN-1:0]             rf_wdata,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   wb_entry_t head;
   logic full, empty, push, pop, pipe_grant, head_wr;
   logic [CW-1:0] starve;
   logic [NREGS-1:1] busy;
   logic [NREGS-1:0] busy_all, set_mask, clr_mask;
   wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   ({mdu_rd, mdu_data}),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );
   assign mdu_ready  = !full;
   assign push       = mdu_valid && !full;
   assign pipe_stall = (starve == CW'(STARVE_LIMIT)) && !empty;
   assign pipe_grant = pipe_we && (pipe_rd != REG_X0) && !pipe_stall;
   // An x0 head is still consumed; it just never reaches the register file
   assign pop        = !empty && !pipe_grant;
   assign head_wr    = pop && (head.rd != REG_X0);
   assign rf_we      = pipe_grant || head_wr;
   assign rf_rd      = pipe_grant ? pipe_rd : head_wr ? head.rd : REG_X0;
   assign rf_wdata   = pipe_grant ? pipe_data : head_wr ? head.data : '0;
   assign set_mask   = issue_valid ? NREGS'(1) << issue_rd : '0;
   assign clr_mask   = head_wr ? NREGS'(1) << head.rd : '0;
   assign busy_all   = {busy, 1'b0};
   assign hazard_rs1 = busy_all[rs1];
   assign hazard_rs2 = busy_all[rs2];
   assign hazard_rd  = busy_all[dec_rd];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         starve <= '0;
         busy   <= '0;
      end else begin
         starve <= (empty || pop) ? '0 : (starve == CW'(STARVE_LIMIT)) ? starve : starve + 1'b1;
         busy   <= (busy & ~clr_mask[NREGS-1:1]) | set_mask[NREGS-1:1];
      end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and random traffic scored against a queue-based model
module tb_wb_port_arbiter;
   import wb_port_arbiter_pkg::*;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;
   logic clk = 0;
   logic rst = 1;
   logic pipe_we, mdu_valid, issue_valid;
   logic [4:0] pipe_rd, mdu_rd, issue_rd, rs1, rs2, dec_rd;
   logic [31:0] pipe_data, mdu_data;
   logic pipe_stall, mdu_ready, hazard_rs1, hazard_rs2, hazard_rd, rf_we;
   logic [4:0] rf_rd;
   logic [31:0] rf_wdata;
   logic [1:0] fifo_count;
   always #5 clk = ~clk;
   wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst), .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
      .pipe_stall(pipe_stall), .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd),
      .mdu_data(mdu_data), .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
      .dec_rd(dec_rd), .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2), .hazard_rd(hazard_rd),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .fifo_count(fifo_count)
   );
   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        stall;
      logic        ready;
      logic [1:0]  cnt;
      logic [2:0]  hz;
   } obs_t;
   obs_t exp_q[$];
   wb_entry_t mq[$];
   int age = 0;
   logic [31:0] mbusy = '0;
   int tests = 0;
   int fails = 0;
   task automatic idle();
      pipe_we = 0; pipe_rd = 0; pipe_data = 0;
      mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
      issue_valid = 0; issue_rd = 0;
   endtask
   // Expected outputs follow from the queue contents, the head's waiting time and the busy set
   task automatic step();
      obs_t e;
      wb_entry_t ent;
      bit emp, stl, pg, pp;
      if (rst) begin
         mq.delete();
         age = 0;
         mbusy = '0;
      end
      emp = mq.size() == 0;
      stl = !emp && age >= LIMIT;
      pg  = pipe_we && pipe_rd != 0 && !stl;
      pp  = !emp && !pg;
      e = '0;
      if (pg) begin
         e.we = 1; e.rd = pipe_rd; e.data = pipe_data;
      end else if (pp && mq[0].rd != 0) begin
         e.we = 1; e.rd = mq[0].rd; e.data = mq[0].data;
      end
      e.stall = stl;
      e.ready = mq.size() < DEPTH;
      e.cnt   = 2'(mq.size());
      e.hz    = {mbusy[dec_rd], mbusy[rs2], mbusy[rs1]};
      if (!rst)
         assert (!(issue_valid && issue_rd != 0 && mbusy[issue_rd]))
         else $error("illegal issue to busy register %0d", issue_rd);
      exp_q.push_back(e);
      @(posedge clk);
      if (!rst) begin
         if (pp) begin
            if (mq[0].rd != 0) mbusy[mq[0].rd] = 0;
            void'(mq.pop_front());
            age = 0;
         end else if (!emp) age = age < LIMIT ? age + 1 : age;
         else age = 0;
         if (mdu_valid && e.ready) begin
            ent.rd = mdu_rd;
            ent.data = mdu_data;
            mq.push_back(ent);
         end
         if (issue_valid && issue_rd != 0) mbusy[issue_rd] = 1;
      end
      #1;
   endtask
   always @(negedge clk)
      if (exp_q.size() > 0) begin
         obs_t e, a;
         e = exp_q.pop_front();
         a = {rf_we, rf_rd, rf_wdata, pipe_stall, mdu_ready, fifo_count, hazard_rd, hazard_rs2, hazard_rs1};
         tests++;
         if (a !== e) begin
            fails++;
            $display("FAIL port t=%0t got we=%b rd=%0d data=%h stall=%b ready=%b cnt=%0d hz=%b required we=%b rd=%0d data=%h stall=%b ready=%b cnt=%0d hz=%b",
                     $time, a.we, a.rd, a.data, a.stall, a.ready, a.cnt, a.hz,
                     e.we, e.rd, e.data, e.stall, e.ready, e.cnt, e.hz);
         end
      end
   initial begin
      idle();
      rs1 = 5; rs2 = 0; dec_rd = 0;
      @(posedge clk); #1;
      step(); step();
      rst = 0;
      pipe_we = 1; pipe_rd = 3; pipe_data = 1;
      mdu_valid = 1; mdu_rd = 8; mdu_data = 2; issue_valid = 1; issue_rd = 8;
      step();
      issue_valid = 0; rs2 = 8;
      step(); step();
      idle(); rst = 1;
      repeat (3) step();
      rst = 0;
      issue_valid = 1; issue_rd = 5;
      step();
      idle();
      step();
      mdu_valid = 1; mdu_rd = 5; mdu_data = 32'hDEADBEEF;
      step();
      idle();
      repeat (3) step();
      pipe_we = 1; pipe_rd = 3; pipe_data = 32'h11;
      mdu_valid = 1; mdu_rd = 7; mdu_data = 32'h77;
      step();
      mdu_valid = 0;
      repeat (7) step();
      for (int k = 0; k < 3; k++) begin
         mdu_valid = 1; mdu_rd = 5'(10 + k); mdu_data = 32'(100 + k);
         for (int n = 0; n < 20; n++) begin
            automatic bit acc = mq.size() < DEPTH;
            step();
            if (acc) break;
         end
      end
      mdu_valid = 0;
      repeat (12) step();
      idle();
      pipe_we = 1; pipe_rd = 0; pipe_data = 32'h55;
      mdu_valid = 1; mdu_rd = 0; mdu_data = 32'h66;
      step();
      mdu_rd = 12; mdu_data = 32'h12;
      step();
      mdu_valid = 0;
      repeat (3) step();
      idle();
      mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h99;
      step();
      idle(); issue_valid = 1; issue_rd = 9;
      step();
      idle(); dec_rd = 9;
      step(); step();
      mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h98;
      step();
      idle();
      repeat (3) step();
      for (int c = 0; c < 1500; c++) begin
         if (c % 300 == 299) begin
            idle(); rst = 1;
            step(); step();
            rst = 0;
         end
         pipe_we   = $urandom_range(0, 9) < 7;
         pipe_rd   = 5'($urandom);
         pipe_data = $urandom;
         mdu_valid = $urandom_range(0, 9) < 4;
         mdu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         mdu_data  = $urandom;
         issue_rd  = 5'($urandom);
         issue_valid = ($urandom_range(0, 4) == 0) && !mbusy[issue_rd];
         rs1 = 5'($urandom); rs2 = 5'($urandom); dec_rd = 5'($urandom);
         step();
      end
      idle();
      step();
      @(negedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
